// File: rtl/fp_to_int_conv.sv
// IEEE-754 single to int32 converter, round toward zero.
// Iterative: one mantissa shift per cycle, saturating on NaN, infinity and out-of-range inputs.
module fp_to_int_conv (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] A,
    output logic [31:0] Y,
    output logic        ready,
    output logic        busy,
    output logic        invalid
);

    typedef enum logic [1:0] {StIdle, StDecode, StShift, StDone} state_e;

    state_e      state_q;
    logic [31:0] a_q;
    logic [31:0] mag_q;
    logic [4:0]  cnt_q;
    logic        left_q;

    logic        sign_a;
    logic [7:0]  exp_a;
    logic [7:0]  unb_exp;
    logic [4:0]  shift_n;
    logic [31:0] mag_full;
    logic [31:0] mag_shift;
    logic [31:0] sat_val;

    always_comb begin
        sign_a    = a_q[31];
        exp_a     = a_q[30:23];
        unb_exp   = exp_a - 8'd127;
        mag_full  = {8'b0, 1'b1, a_q[22:0]};
        mag_shift = left_q ? (mag_q << 1) : (mag_q >> 1);
        sat_val   = sign_a ? 32'h8000_0000 : 32'h7FFF_FFFF;
        if (unb_exp < 8'd23) begin
            shift_n = 5'(8'd23 - unb_exp);
        end else begin
            shift_n = 5'(unb_exp - 8'd23);
        end
    end

    function automatic logic [31:0] apply_sign(input logic neg, input logic [31:0] m);
        return neg ? (~m + 32'd1) : m;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            Y       <= 32'd0;
            ready   <= 1'b0;
            busy    <= 1'b0;
            invalid <= 1'b0;
            a_q     <= 32'd0;
            mag_q   <= 32'd0;
            cnt_q   <= 5'd0;
            left_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    ready <= 1'b0;
                    if (start) begin
                        a_q     <= A;
                        busy    <= 1'b1;
                        state_q <= StDecode;
                    end
                end
                StDecode: begin
                    // Every path except a non-zero shift completes on this edge.
                    state_q <= StDone;
                    ready   <= 1'b1;
                    busy    <= 1'b0;
                    if (exp_a == 8'd255) begin
                        Y       <= (!sign_a && a_q[22:0] == 23'd0) ? 32'h7FFF_FFFF
                                                                   : 32'h8000_0000;
                        invalid <= 1'b1;
                    end else if (exp_a < 8'd127) begin
                        Y       <= 32'd0;
                        invalid <= 1'b0;
                    end else if (unb_exp >= 8'd31) begin
                        // -2^31 is the one representable value with an exponent this large.
                        Y       <= (a_q == 32'hCF00_0000) ? 32'h8000_0000 : sat_val;
                        invalid <= (a_q != 32'hCF00_0000);
                    end else begin
                        mag_q  <= mag_full;
                        cnt_q  <= shift_n;
                        left_q <= (unb_exp > 8'd23);
                        if (shift_n == 5'd0) begin
                            Y       <= apply_sign(sign_a, mag_full);
                            invalid <= 1'b0;
                        end else begin
                            state_q <= StShift;
                            ready   <= 1'b0;
                            busy    <= 1'b1;
                        end
                    end
                end
                StShift: begin
                    mag_q <= mag_shift;
                    cnt_q <= cnt_q - 5'd1;
                    if (cnt_q == 5'd1) begin
                        Y       <= apply_sign(sign_a, mag_shift);
                        invalid <= 1'b0;
                        ready   <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    ready   <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_to_int_conv.sv
// Bench for fp_to_int_conv: directed vector table, random operands against a value-level
// model, and hand-written start-while-busy and mid-conversion reset sequences.
module tb_fp_to_int_conv;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] A;
    logic [31:0] Y;
    logic        ready;
    logic        busy;
    logic        invalid;

    int errors = 0;
    int checks = 0;

    fp_to_int_conv dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .A      (A),
        .Y      (Y),
        .ready  (ready),
        .busy   (busy),
        .invalid(invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] y;
        logic        inv;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Value-level reference: exact real value of the float, truncated, range-checked.
    function automatic void model(input logic [31:0] a, output logic [31:0] y,
                                  output logic inv, output int lat);
        int     e;
        longint mag;
        longint v;
        e = int'(a[30:23]);
        lat = 2;
        inv = 1'b0;
        if (e == 255) begin
            inv = 1'b1;
            y = (a[31] == 1'b0 && a[22:0] == 23'd0) ? 32'h7FFF_FFFF : 32'h8000_0000;
        end else if (e < 127) begin
            y = 32'd0;
        end else if (e > 181) begin
            inv = 1'b1;
            y = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else begin
            mag = longint'({1'b1, a[22:0]});
            if (e >= 150) mag = mag <<< (e - 150);
            else          mag = mag >>> (150 - e);
            v = a[31] ? -mag : mag;
            if (v > 64'sd2147483647 || v < -64'sd2147483648) begin
                inv = 1'b1;
                y = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
            end else begin
                y = v[31:0];
                lat = 2 + ((e >= 150) ? (e - 150) : (150 - e));
            end
        end
    endfunction

    // Start in cycle 0, scramble A afterwards, wait for ready and check everything.
    task automatic convert(input logic [31:0] a, input logic [31:0] ey, input logic ei,
                           input int elat, input string name);
        int   cyc;
        logic got;
        logic busy_ok;
        @(negedge clk);
        start = 1'b1;
        A = a;
        @(posedge clk);
        #1;
        start = 1'b0;
        A = $urandom;
        cyc = 1;
        got = 1'b0;
        busy_ok = 1'b1;
        while (!got && cyc <= 40) begin
            @(negedge clk);
            if (ready) begin
                got = 1'b1;
            end else begin
                if (!busy) busy_ok = 1'b0;
                cyc++;
            end
        end
        check({name, " latency"}, 32'(cyc), 32'(elat));
        check({name, " Y"}, Y, ey);
        check({name, " invalid"}, 32'(invalid), 32'(ei));
        check({name, " busy"}, 32'({busy_ok, busy}), 32'b10);
    endtask

    vec_t vecs[$];

    initial begin
        logic [31:0] ra;
        logic [31:0] ry;
        logic        rinv;
        int          rlat;
        int          pulses;
        int          rcyc;

        rst = 1'b1;
        start = 1'b1;
        A = 32'h4040_0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset Y", Y, 32'd0);
        check("reset flags", 32'({ready, busy, invalid}), 32'd0);
        rst = 1'b0;
        start = 1'b0;

        vecs.push_back('{32'h4040_0000, 32'h0000_0003, 1'b0, 24});
        vecs.push_back('{32'hC030_0000, 32'hFFFF_FFFE, 1'b0, 24});
        vecs.push_back('{32'h3F00_0000, 32'h0000_0000, 1'b0, 2});
        vecs.push_back('{32'h4E80_0000, 32'h4000_0000, 1'b0, 9});
        vecs.push_back('{32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 2});
        vecs.push_back('{32'hCF00_0000, 32'h8000_0000, 1'b0, 2});
        vecs.push_back('{32'h7FC0_0000, 32'h8000_0000, 1'b1, 2});
        vecs.push_back('{32'hFF80_0000, 32'h8000_0000, 1'b1, 2});
        vecs.push_back('{32'h7F80_0000, 32'h7FFF_FFFF, 1'b1, 2});
        vecs.push_back('{32'h3F80_0000, 32'h0000_0001, 1'b0, 25});
        vecs.push_back('{32'h4B00_0000, 32'h0080_0000, 1'b0, 2});
        vecs.push_back('{32'h8000_0000, 32'h0000_0000, 1'b0, 2});
        vecs.push_back('{32'hCEFF_FFFF, 32'h8000_0080, 1'b0, 9});
        vecs.push_back('{32'hCF00_0001, 32'h8000_0000, 1'b1, 2});
        foreach (vecs[i]) begin
            convert(vecs[i].a, vecs[i].y, vecs[i].inv, vecs[i].lat, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 250; i++) begin
            ra = $urandom;
            if (i % 8 != 0) ra[30:23] = 8'($urandom_range(118, 162));
            model(ra, ry, rinv, rlat);
            convert(ra, ry, rinv, rlat, $sformatf("rand 0x%08h", ra));
        end

        // Start held high with a different operand while busy: must be ignored.
        @(negedge clk);
        start = 1'b1;
        A = 32'h4040_0000;
        @(posedge clk);
        pulses = 0;
        rcyc = 0;
        for (int c = 1; c <= 35; c++) begin
            @(negedge clk);
            if (ready) begin
                pulses++;
                if (rcyc == 0) rcyc = c;
            end
            start = (c <= 10);
            A = 32'h40A0_0000;
        end
        start = 1'b0;
        check("busy-start pulses", 32'(pulses), 32'd1);
        check("busy-start latency", 32'(rcyc), 32'd24);
        check("busy-start Y", Y, 32'd3);
        repeat (5) @(negedge clk);
        check("held Y", Y, 32'd3);
        check("held flags", 32'({ready, busy, invalid}), 32'd0);

        // Reset at cycle 10 aborts; a fresh start in cycle 12 completes in cycle 36.
        @(negedge clk);
        start = 1'b1;
        A = 32'h4040_0000;
        @(posedge clk);
        rcyc = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (ready && rcyc == 0) rcyc = c;
            if (c == 1) start = 1'b0;
            if (c == 10) rst = 1'b1;
            if (c == 11) begin
                check("rst busy", 32'(busy), 32'd0);
                check("rst Y", Y, 32'd0);
                check("rst ready", 32'(ready), 32'd0);
                rst = 1'b0;
            end
            if (c == 12) begin
                start = 1'b1;
                A = 32'h4040_0000;
            end
            if (c == 13) begin
                start = 1'b0;
                A = 32'hDEAD_BEEF;
            end
        end
        check("post-rst ready cycle", 32'(rcyc), 32'd36);
        check("post-rst Y", Y, 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fp_to_int_conv.md
FP_TO_INT_CONV -- requirements
Module: fp_to_int_conv

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at IEEE-754 single precision in and 32-bit two's-complement out.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high, sampled on the rising edge of clk.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 A  input  32  IEEE-754 single operand (adder_fp result Y); captured on the accepting edge.
REQ-006 Y  output  32  signed integer result, round toward zero; held until the next completion.
REQ-007 ready  output  1  one-cycle completion pulse; Y and invalid are valid in this cycle.
REQ-008 busy  output  1  high while a conversion is in progress (DECODE, SHIFT).
REQ-009 invalid  output  1  set with the result when A is NaN, infinity or out of int32 range; held with Y.

Function
REQ-010 FSM states SHALL be IDLE, DECODE, SHIFT, DONE.
REQ-011 IDLE with start=1 SHALL latch A and go to DECODE; IDLE with start=0 SHALL stay in IDLE.
REQ-012 In DECODE, fields SHALL be s=A[31], e=A[30:23], u=e-127.
REQ-013 DECODE, e=255: go to DONE; result 0x7FFFFFFF for +inf, 0x80000000 for -inf and for any NaN; invalid=1.
REQ-014 DECODE, e<127 (zero, denormal, |x|<1, -0): go to DONE; result 0, invalid=0.
REQ-015 DECODE, u>=31: go to DONE; A=0xCF000000 gives 0x80000000 with invalid=0; otherwise saturate to 0x7FFFFFFF (s=0) or 0x80000000 (s=1) with invalid=1.
REQ-016 DECODE, otherwise: load magnitude M={8'b0,1'b1,A[22:0]} and shift count N=|u-23| (right if u<23, left if u>23); go to SHIFT if N>0, else go to DONE.
REQ-017 SHIFT SHALL shift M by exactly one bit per cycle in the decided direction and decrement N.
REQ-018 Right shifts SHALL discard the shifted-out bits (truncation).
REQ-019 SHIFT SHALL go to DONE on the edge where N reaches 0.
REQ-020 The edge entering DONE SHALL update Y to M (s=0) or the two's-complement negation of M (s=1), and SHALL update invalid.
REQ-021 DONE SHALL last exactly one cycle with ready=1 and busy=0, then return to IDLE unconditionally.
REQ-022 start in DONE SHALL be ignored.
REQ-023 Latency: with start high in cycle 0, ready SHALL be high in cycle 2+N, where N=0 for every case in REQ-013 to REQ-015.
REQ-024 Maximum latency SHALL be 25 cycles (u=0, N=23).
REQ-025 start while busy=1 SHALL be ignored; A changes after the accepting edge SHALL NOT affect the result.
REQ-026 busy SHALL be 1 in DECODE and SHIFT and 0 in IDLE and DONE; ready SHALL be 0 outside DONE.

Reset
REQ-027 rst=1 at a rising edge SHALL force IDLE and set Y=0, ready=0, busy=0, invalid=0, overriding start.
REQ-028 rst mid-conversion SHALL abort it with no ready pulse; the first start sampled after rst deasserts SHALL be accepted normally.

Verification
REQ-029 A=0x40400000 (3.0), start pulsed in cycle 0 -> busy in cycles 1-23, ready in cycle 24, Y=3, invalid=0.
REQ-030 A=0xC0300000 (-2.75) -> Y=0xFFFFFFFE (-2), invalid=0; then A=0x3F000000 (0.5) -> ready in cycle 2, Y=0.
REQ-031 A=0x4E800000 (2^30) -> left shift N=7, ready in cycle 9, Y=0x40000000.
REQ-032 Boundary operands:
- 0x4F000000 -> Y=0x7FFFFFFF, invalid=1.
- 0xCF000000 -> Y=0x80000000, invalid=0.
- 0x7FC00000 (NaN) -> Y=0x80000000, invalid=1.
- 0xFF800000 (-inf) -> Y=0x80000000, invalid=1.
- Each ready in cycle 2.
REQ-033 Start 3.0, then start=1 with A=0x40A00000 during cycles 1-10 -> single ready in cycle 24, Y=3; then Y and invalid are held while idle.
REQ-034 Start 3.0, rst=1 in cycle 10 -> cycle 11 shows busy=0, Y=0, ready=0, and no ready pulse follows; a new start in cycle 12 completes normally in cycle 36.
